// File: rtl/float_mul.sv
// float_mul: multi-cycle IEEE-754 single-precision multiplier.
// Operands are unpacked on start. Special operands are resolved in one cycle.
// Otherwise a 24-iteration shift-add loop forms the 48-bit significand
// product, which is then normalized (truncation), packed and flagged.
// Denormal operands are flushed to zero.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset
//   ix    - multiplicand (IEEE-754 single), sampled when start is accepted
//   iy    - multiplier   (IEEE-754 single), sampled when start is accepted
//   start - request, accepted only while idle
//   oz    - result, held until the next result is written
//   flag  - 00 normal, 01 overflow, 10 underflow, 11 invalid
//   busy  - high whenever the unit is not idle
//   done  - one-cycle pulse while the result is presented
module float_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ix,
  input  logic [31:0] iy,
  input  logic        start,
  output logic [31:0] oz,
  output logic [1:0]  flag,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, CHECK, MUL, NORM, DONE} state_t;

  state_t             state;
  logic               s;
  logic [7:0]         ex, ey;
  logic [22:0]        fx, fy;
  logic [23:0]        mx, my;
  logic [47:0]        acc;
  logic [4:0]         cnt;
  logic signed [9:0]  e;

  // Operand classification (exponent 0 counts as zero, denormals flushed)
  logic x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
  assign x_nan  = (ex == 8'hFF) && (fx != '0);
  assign y_nan  = (ey == 8'hFF) && (fy != '0);
  assign x_inf  = (ex == 8'hFF) && (fx == '0);
  assign y_inf  = (ey == 8'hFF) && (fy == '0);
  assign x_zero = (ex == 8'h00);
  assign y_zero = (ey == 8'h00);

  // Normalization of the finished product
  logic signed [9:0] e_n;
  logic [22:0]       mant;
  always_comb begin
    e_n  = e;
    mant = acc[45:23];
    if (acc[47]) begin
      e_n  = e + 10'sd1;
      mant = acc[46:24];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      s     <= 1'b0;
      ex    <= '0;
      ey    <= '0;
      fx    <= '0;
      fy    <= '0;
      mx    <= '0;
      my    <= '0;
      acc   <= '0;
      cnt   <= '0;
      e     <= '0;
      oz    <= '0;
      flag  <= 2'b00;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            s     <= ix[31] ^ iy[31];
            ex    <= ix[30:23];
            ey    <= iy[30:23];
            fx    <= ix[22:0];
            fy    <= iy[22:0];
            busy  <= 1'b1;
            state <= CHECK;
          end
        end

        CHECK: begin
          if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) begin
            oz    <= 32'h7FC0_0000;
            flag  <= 2'b11;
            done  <= 1'b1;
            state <= DONE;
          end else if (x_inf || y_inf) begin
            oz    <= {s, 8'hFF, 23'd0};
            flag  <= 2'b01;
            done  <= 1'b1;
            state <= DONE;
          end else if (x_zero || y_zero) begin
            oz    <= {s, 8'h00, 23'd0};
            flag  <= 2'b00;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            mx    <= {1'b1, fx};
            my    <= {1'b1, fy};
            acc   <= '0;
            cnt   <= '0;
            e     <= $signed({2'b00, ex}) + $signed({2'b00, ey}) - 10'sd127;
            state <= MUL;
          end
        end

        MUL: begin
          // The multiplicand is shifted by the iteration count rather than
          // kept in a shifting register.
          if (my[0])
            acc <= acc + ({24'd0, mx} << cnt);
          my  <= my >> 1;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd23)
            state <= NORM;
        end

        NORM: begin
          if (e_n >= 10'sd255) begin
            oz   <= {s, 8'hFF, 23'd0};
            flag <= 2'b01;
          end else if (e_n <= 10'sd0) begin
            oz   <= {s, 8'h00, 23'd0};
            flag <= 2'b10;
          end else begin
            oz   <= {s, e_n[7:0], mant};
            flag <= 2'b00;
          end
          done  <= 1'b1;
          state <= DONE;
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_mul.sv
module tb_float_mul;

  logic        clk;
  logic        rst;
  logic [31:0] ix, iy;
  logic        start;
  logic [31:0] oz;
  logic [1:0]  flag;
  logic        busy;
  logic        done;

  int checks;
  int failures;
  int cyc;

  typedef struct {
    logic [31:0] oz;
    logic [1:0]  flag;
    int          done_cyc;
  } exp_t;

  exp_t q[$];

  float_mul dut (
    .clk  (clk),
    .rst  (rst),
    .ix   (ix),
    .iy   (iy),
    .start(start),
    .oz   (oz),
    .flag (flag),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: IEEE single multiply with flushed denormals and
  // truncation, using plain integer arithmetic. Returns {flag, oz}.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    int          ex, ey, fx, fy, e;
    longint      p, m;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    fx = int'(x[22:0]);
    fy = int'(y[22:0]);
    if ((ex == 255 && fx != 0) || (ey == 255 && fy != 0))
      return {2'b11, 32'h7FC0_0000};
    if ((ex == 255 && ey == 0) || (ey == 255 && ex == 0))
      return {2'b11, 32'h7FC0_0000};
    if (ex == 255 || ey == 255)
      return {2'b01, s, 8'hFF, 23'd0};
    if (ex == 0 || ey == 0)
      return {2'b00, s, 31'd0};
    p = longint'(fx + 32'h80_0000) * longint'(fy + 32'h80_0000);
    e = ex + ey - 127;
    if (p >= (64'sd1 <<< 47)) begin
      m = (p >>> 24) & 64'h7F_FFFF;
      e = e + 1;
    end else begin
      m = (p >>> 23) & 64'h7F_FFFF;
    end
    if (e >= 255) return {2'b01, s, 8'hFF, 23'd0};
    if (e <= 0)   return {2'b10, s, 31'd0};
    return {2'b00, s, e[7:0], m[22:0]};
  endfunction

  function automatic bit is_special(input logic [31:0] x, input logic [31:0] y);
    return (x[30:23] == 8'hFF) || (y[30:23] == 8'hFF) ||
           (x[30:23] == 8'h00) || (y[30:23] == 8'h00);
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t ex_e;
      checks = checks + 1;
      if (q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL spurious_done at cycle %0d oz=%h flag=%b, none expected", cyc, oz, flag);
      end else begin
        ex_e = q.pop_front();
        if (oz !== ex_e.oz || flag !== ex_e.flag) begin
          failures = failures + 1;
          $display("FAIL result got oz=%h flag=%b expected oz=%h flag=%b",
                   oz, flag, ex_e.oz, ex_e.flag);
        end
        checks = checks + 1;
        if (cyc != ex_e.done_cyc) begin
          failures = failures + 1;
          $display("FAIL done_cycle got %0d expected %0d", cyc, ex_e.done_cyc);
        end
      end
    end
  end

  // Issue one operation and follow it to completion. If poke is set, a
  // second start is pulsed while the unit is busy; it must be ignored.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] e_oz, input logic [1:0] e_flag,
                        input bit poke);
    exp_t  ent;
    int    n, lat;
    bit    seen, busy_bad;
    lat = is_special(x, y) ? 2 : 27;
    @(posedge clk); #1;
    ix = x; iy = y; start = 1'b1;
    n = cyc;
    ent.oz = e_oz; ent.flag = e_flag; ent.done_cyc = n + lat;
    q.push_back(ent);
    @(posedge clk); #1;
    start = 1'b0;
    ix = $urandom; iy = $urandom;
    seen = 1'b0;
    busy_bad = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (poke && k == 5) begin
        ix = 32'h3F80_0000; iy = 32'h3F80_0000; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    checks = checks + 1;
    if (!seen) begin
      failures = failures + 1;
      $display("FAIL timeout no done within 40 cycles for %h x %h", x, y);
      q.delete();
    end
    checks = checks + 1;
    if (busy_bad) begin
      failures = failures + 1;
      $display("FAIL busy_window busy low before done for %h x %h", x, y);
    end
    @(negedge clk);
    checks = checks + 1;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL idle_after got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: r[30:23] = 8'h00;                        // zero / denormal
      1: r[30:23] = 8'hFF;                        // inf or NaN
      2: begin r[30:23] = 8'hFF; r[22:0] = '0; end // inf
      3: r[30:23] = 8'(($urandom_range(0, 9)) + 1);   // tiny
      4: r[30:23] = 8'(254 - $urandom_range(0, 9));   // huge
      5: r[30:23] = 8'(127 + $urandom_range(0, 6) - 3);
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    logic [33:0] m;
    logic [31:0] a, b;
    int          n;
    checks = 0;
    failures = 0;
    cyc = 0;
    rst = 1'b1;
    start = 1'b0;
    ix = '0;
    iy = '0;
    repeat (3) @(posedge clk);
    #1;
    checks = checks + 1;
    if (oz !== 32'd0 || flag !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL reset_state got oz=%h flag=%b busy=%b done=%b expected all 0",
               oz, flag, busy, done);
    end
    rst = 1'b0;

    // Directed cases with hand-derived results
    run_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 2'b00, 1'b0);
    run_op(32'h3FC0_0000, 32'hBFC0_0000, 32'hC010_0000, 2'b00, 1'b0);
    run_op(32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 2'b01, 1'b0);
    run_op(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 2'b10, 1'b0);
    run_op(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 2'b11, 1'b0);
    run_op(32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 2'b00, 1'b0);
    run_op(32'hFFC1_2345, 32'h3F80_0000, 32'h7FC0_0000, 2'b11, 1'b0);
    run_op(32'h3F80_0000, 32'hFF80_0000, 32'hFF80_0000, 2'b01, 1'b0);

    // Start pulsed while busy is ignored: one done, result unchanged
    run_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 2'b00, 1'b1);
    repeat (40) @(negedge clk);
    checks = checks + 1;
    if (oz !== 32'h40C0_0000 || flag !== 2'b00) begin
      failures = failures + 1;
      $display("FAIL ignored_start got oz=%h flag=%b expected oz=40c00000 flag=00", oz, flag);
    end

    // Reset mid-multiply: outputs clear immediately, no clock edge needed
    run_op(32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 2'b00, 1'b0);
    @(posedge clk); #1;
    ix = 32'h4000_0000; iy = 32'h4040_0000; start = 1'b1;
    n = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < n + 10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks = checks + 1;
    if (oz !== 32'd0 || flag !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL async_reset got oz=%h flag=%b busy=%b done=%b expected all 0",
               oz, flag, busy, done);
    end
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checks = checks + 1;
    if (busy !== 1'b0 || oz !== 32'd0) begin
      failures = failures + 1;
      $display("FAIL after_reset got busy=%b oz=%h expected busy=0 oz=0", busy, oz);
    end

    // Randomized operands against the reference model
    for (int i = 0; i < 30; i++) begin
      a = rand_operand();
      b = rand_operand();
      m = model(a, b);
      run_op(a, b, m[31:0], m[33:32], 1'b0);
    end

    repeat (5) @(negedge clk);
    checks = checks + 1;
    if (q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL pending got %0d outstanding results expected 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/float_mul.md
# float_mul

Multi-cycle IEEE-754 single-precision multiplier; the companion to the ALU's floating-point divider, completing the multiply/divide pair in the same ALU datapath. It accepts two operands on a start strobe and unpacks them. Specials are resolved in one cycle. Otherwise it forms the 48-bit significand product with a 24-iteration shift-add loop, then normalizes, packs, and pulses done with an exception flag.

## Interface
- No parameters (format fixed at 32-bit single precision).
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ix  input  32  multiplicand, IEEE-754 single; sampled only when start is accepted.
- iy  input  32  multiplier, IEEE-754 single; sampled only when start is accepted.
- start  input  1  request; accepted only in IDLE.
- oz  output  32  result; holds its value until the next result is written.
- flag  output  2  status of oz:
  - 00 = normal
  - 01 = overflow
  - 10 = underflow
  - 11 = invalid
- busy  output  1  high in every state except IDLE.
- done  output  1  high for exactly the one cycle spent in DONE.

## Operation
- States: IDLE, CHECK, MUL, NORM, DONE.
- IDLE:
  - On start=1, latch sign, 8-bit exponent and 23-bit fraction of ix and iy, then go to CHECK.
  - If start=0, stay in IDLE.
- Sign rule: s = sx ^ sy everywhere, including specials.
- Exponent 0 (zero or denormal) is treated as zero; denormals are flushed.
- CHECK, special cases in priority order; each writes oz and flag, then goes to DONE:
  - Either operand NaN (exp FF, frac != 0): oz = 7FC00000, flag 11.
  - Infinity times zero (either order): oz = 7FC00000, flag 11.
  - Either operand infinity: oz = {s, FF, 0}, flag 01.
  - Either operand zero: oz = {s, 00, 0}, flag 00.
  - Otherwise: load significands {1, frac}, clear the 48-bit accumulator and 5-bit counter, compute e = ex + ey − 127 in 10-bit signed, go to MUL.
- MUL: one iteration per cycle, 24 iterations.
  - Iteration: if the current multiplier LSB is 1, add the multiplicand, shifted by the counter, to the accumulator; then shift the multiplier right and increment the counter.
  - After iteration 24 (counter == 23 at that edge), go to NORM.
- NORM, with P = 48-bit product:
  - If P[47]=1: mantissa = P[46:24], e = e + 1.
  - Else: mantissa = P[45:23].
  - Rounding is truncation.
  - Then classify e:
    - e ≥ 255: oz = {s, FF, 0}, flag 01.
    - e ≤ 0: oz = {s, 00, 0}, flag 10.
    - Else: oz = {s, e[7:0], mantissa}, flag 00.
  - Go to DONE.
- DONE: assert done; next edge go to IDLE.
- start is ignored outside IDLE, including in DONE; there is no queuing.
- ix and iy may change freely after acceptance.

## Timing
- Reset (async, any state, including mid-MUL): state IDLE, oz = 0, flag = 00, busy = 0, done = 0, accumulator and counter cleared.
- First start accepted one edge after rst deasserts.
- Let start be high in IDLE during cycle n.
- Normal path:
  - CHECK in cycle n+1.
  - MUL in cycles n+2..n+25.
  - NORM in n+26.
  - DONE in n+27, where done = 1 and oz/flag are valid.
  - IDLE in n+28.
- Special path: DONE in cycle n+2.
- oz/flag change only on the edge entering DONE; they are stable during done and afterwards.
- Back-to-back: the earliest next accept is the IDLE cycle following DONE, i.e. one op per 28 cycles for normal operands.

## Test plan
- 40000000 × 40400000 (2.0×3.0) → oz = 40C00000, flag 00.
  - done high exactly in cycle n+27, busy high n+1..n+27.
- 3FC00000 × BFC00000 (1.5×−1.5) → oz = C0100000, flag 00 (exercises the P[47] normalization path).
- 7F000000 × 40000000 → oz = 7F800000, flag 01.
- 00800000 × 3F000000 → oz = 00000000, flag 10.
- 7F800000 × 00000000 → oz = 7FC00000, flag 11, with done in cycle n+2.
- 80000000 × 3F800000 → oz = 80000000, flag 00, with done in cycle n+2.
- Start 40000000 × 40400000, assert rst in cycle n+10:
  - Outputs are 0 immediately, without waiting for a clock edge.
  - A start pulsed during busy in a separate run is ignored: one done only and oz unchanged by it.
